// File: rtl/rc5_key_encoder.sv
// rc5_key_encoder
//   Keypad front end for the RC-5 transmitter. Each raw button is
//   synchronised and debounced. The lowest-index pressed key is chosen,
//   and a 14-bit RC-5 frame {1,1,toggle,ADDRESS,cmd} is built from it and
//   offered to the Manchester serialiser over a valid/ready handshake.
//   A held key repeats its frame after a fixed gap with the toggle unchanged.
//   Each new press flips the toggle.
//
// Ports
//   clock        : single rising-edge clock
//   reset        : synchronous, active-high
//   keys         : raw asynchronous buttons, 1 = pressed
//   frame_ready  : serialiser can accept a frame
//   frame_valid  : frame holds a frame to transmit
//   frame        : {1,1,toggle,ADDRESS,cmd}, bit 13 transmitted first
//   toggle       : current RC-5 toggle bit
//   key_active   : a key is latched (SEND or GAP)
//   key_index    : index of the latched key
module rc5_key_encoder #(
    parameter int                    NUM_KEYS        = 5,
    parameter int                    DEBOUNCE_CYCLES = 100000,
    parameter int                    REPEAT_GAP      = 5000000,
    parameter logic [4:0]            ADDRESS         = 5'b00000,
    parameter logic [NUM_KEYS*6-1:0] CMD_TABLE       = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                frame_ready,
    output logic                frame_valid,
    output logic [13:0]         frame,
    output logic                toggle,
    output logic                key_active,
    output logic [3:0]          key_index
);

    // Counters only need to reach N-1, so $clog2(N) bits suffice.
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GAP_W = (REPEAT_GAP > 1) ? $clog2(REPEAT_GAP) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REPEAT_GAP - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] db_q;
    logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];

    state_t             state_q,  state_d;
    logic               valid_q,  valid_d;
    logic [13:0]        frame_q,  frame_d;
    logic               toggle_q, toggle_d;
    logic [3:0]         idx_q,    idx_d;
    logic [GAP_W-1:0]   gap_q,    gap_d;

    logic               any_pressed;
    logic [3:0]         pri_idx;
    logic [15:0]        db_pad;

    // Command lookup; idx compared against each valid key so that an
    // out-of-range index simply yields zero.
    function automatic logic [5:0] key_cmd(input logic [3:0] idx);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (idx == 4'(i)) begin
                c = CMD_TABLE[6*i +: 6];
            end
        end
        return c;
    endfunction

    // Two-flop synchroniser followed by per-key debounce. The debounced
    // level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        pri_idx     = '0;
        any_pressed = |db_q;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (db_q[i]) begin
                pri_idx = 4'(i);
            end
        end
    end

    // Zero-padded copy so the 4-bit latched index can address it directly.
    assign db_pad = 16'(db_q);

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        frame_d  = frame_q;
        toggle_d = toggle_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (any_pressed) begin
                    idx_d    = pri_idx;
                    toggle_d = ~toggle_q;
                    frame_d  = {2'b11, ~toggle_q, ADDRESS, key_cmd(pri_idx)};
                    valid_d  = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // Key release here is deliberately ignored: the frame goes out.
                if (valid_q && frame_ready) begin
                    valid_d = 1'b0;
                    gap_d   = GAP_LAST;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    // Repeat keeps frame and toggle exactly as they were.
                    if (db_pad[idx_q]) begin
                        valid_d = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            frame_q  <= '0;
            toggle_q <= 1'b0;
            idx_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
            toggle_q <= toggle_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
        end
    end

    assign frame_valid = valid_q;
    assign frame       = frame_q;
    assign toggle      = toggle_q;
    assign key_active  = (state_q != IDLE);
    assign key_index   = idx_q;

endmodule

// File: tb/tb_rc5_key_encoder.sv
module tb_rc5_key_encoder;

    localparam int          NK   = 5;
    localparam int          DB   = 4;
    localparam int          RG   = 20;
    localparam logic [4:0]  ADDR = 5'b00011;
    localparam logic [29:0] CMDT = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys = '0;
    logic          frame_ready = 1'b1;
    logic          frame_valid;
    logic [13:0]   frame;
    logic          toggle;
    logic          key_active;
    logic [3:0]    key_index;

    always #5 clock = ~clock;

    rc5_key_encoder #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_GAP      (RG),
        .ADDRESS         (ADDR),
        .CMD_TABLE       (CMDT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .keys        (keys),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame       (frame),
        .toggle      (toggle),
        .key_active  (key_active),
        .key_index   (key_index)
    );

    typedef struct {
        logic [13:0] frame;
        logic [3:0]  idx;
        int          gap;   // required cycles since previous transfer, 0 = unchecked
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_xfer = 0;
    bit   chk_next = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [13:0] f, input logic [3:0] i, input int g);
        exp_t e;
        e.frame = f;
        e.idx   = i;
        e.gap   = g;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        keys        = '0;
        frame_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!frame_valid && k < 60) begin
            tick(1);
            k++;
        end
    endtask

    // Monitor: every accepted transfer is compared against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (chk_next) begin
                check("valid_drop_after_xfer", frame_valid, 0);
                chk_next = 1'b0;
            end
            if (frame_valid && frame_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %b expected none", frame);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("frame", frame, mon_e.frame);
                    check("toggle", toggle, mon_e.frame[11]);
                    check("key_index", key_index, mon_e.idx);
                    if (mon_e.gap != 0) begin
                        check("repeat_spacing", cyc - last_xfer, mon_e.gap);
                    end
                end
                last_xfer = cyc;
                chk_next  = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [13:0] held;
        bit          bad;

        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame", frame, 0);
        check("rst_toggle", toggle, 0);
        check("rst_key_active", key_active, 0);
        check("rst_key_index", key_index, 0);
        reset = 1'b0;
        tick(2);

        // Single press of key 2
        push(14'b11_1_00011_000011, 4'd2, 0);
        keys = 5'b00100;
        wait_valid(k);
        check("press_latency", k, 7);
        tick(10 - k);
        keys = '0;
        tick(40);
        check("single_press_idle", key_active, 0);

        // Glitch shorter than the debounce window
        do_reset();
        keys = 5'b00001;
        tick(3);
        keys = '0;
        bad = 1'b0;
        repeat (20) begin
            if (key_active || frame_valid) bad = 1'b1;
            tick(1);
        end
        check("glitch_ignored", bad, 0);

        // Held key 1: four frames, 21 cycles apart, toggle unchanged
        do_reset();
        push(14'b11_1_00011_000010, 4'd1, 0);
        push(14'b11_1_00011_000010, 4'd1, 21);
        push(14'b11_1_00011_000010, 4'd1, 21);
        push(14'b11_1_00011_000010, 4'd1, 21);
        keys = 5'b00010;
        tick(80);
        keys = '0;
        k = 0;
        while (key_active && k < 60) begin
            tick(1);
            k++;
        end
        check("idle_at_gap_end", k, 11);
        tick(10);

        // Key 4 twice: second press flips toggle
        do_reset();
        push(14'b11_1_00011_000101, 4'd4, 0);
        keys = 5'b10000;
        tick(10);
        keys = '0;
        tick(40);
        push(14'b11_0_00011_000101, 4'd4, 0);
        keys = 5'b10000;
        tick(10);
        keys = '0;
        tick(40);

        // Keys 3 and 1 together: key 1 wins
        do_reset();
        push(14'b11_1_00011_000010, 4'd1, 0);
        keys = 5'b01010;
        tick(10);
        keys = '0;
        tick(40);

        // Stall for 15 cycles, then accept
        do_reset();
        frame_ready = 1'b0;
        push(14'b11_1_00011_000011, 4'd2, 0);
        keys = 5'b00100;
        wait_valid(k);
        check("stall_press_latency", k, 7);
        held = frame;
        keys = '0;
        bad = 1'b0;
        repeat (15) begin
            tick(1);
            if (!frame_valid || frame !== held) bad = 1'b1;
        end
        check("stall_hold", bad, 0);
        frame_ready = 1'b1;
        tick(40);

        // Stall, then reset discards the pending frame
        do_reset();
        frame_ready = 1'b0;
        keys = 5'b01000;
        wait_valid(k);
        check("stall2_press_latency", k, 7);
        check("stall2_frame", frame, 14'b11_1_00011_000100);
        held = frame;
        bad = 1'b0;
        repeat (15) begin
            tick(1);
            if (!frame_valid || frame !== held) bad = 1'b1;
        end
        check("stall2_hold", bad, 0);
        reset = 1'b1;
        keys  = '0;
        tick(1);
        check("midsend_rst_valid", frame_valid, 0);
        check("midsend_rst_toggle", toggle, 0);
        check("midsend_rst_key_active", key_active, 0);
        reset = 1'b0;
        tick(2);
        frame_ready = 1'b1;
        tick(30);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc5_key_encoder.md
# rc5_key_encoder

Parametrised keypad front end for the RC-5 transmitter. It synchronises and debounces `NUM_KEYS` raw buttons and selects one key by fixed priority. It then assembles a full 14-bit RC-5 frame (start bits, toggle, address, command) and hands it to the Manchester serialiser over a valid/ready handshake. Held keys are auto-repeated at a fixed spacing with an unchanged toggle bit, and each new press flips the toggle bit.

## Interface
- `NUM_KEYS`, 5, number of button inputs (1..16)
- `DEBOUNCE_CYCLES`, 100000, consecutive stable cycles needed to accept a key level change (≥1)
- `REPEAT_GAP`, 5000000, clock cycles from frame handoff to the next repeat decision (≥1)
- `ADDRESS`, 5'b00000, RC-5 system address placed in every frame
- `CMD_TABLE`, all zeros, `NUM_KEYS*6` bits; command for key i is `CMD_TABLE[6*i+5:6*i]`
- `clock` in 1: single clock; all logic rising-edge
- `reset` in 1: synchronous, active-high
- `keys` in NUM_KEYS: raw asynchronous buttons, 1 = pressed
- `frame_ready` in 1: serialiser can accept a frame
- `frame_valid` out 1: `frame` holds a frame to transmit
- `frame` out 14: `{1,1,toggle,ADDRESS,cmd}`, bit 13 sent first
- `toggle` out 1: current RC-5 toggle bit
- `key_active` out 1: a debounced key is latched (FSM not IDLE)
- `key_index` out 4: index of the latched key

## Operation
- Per key: 2-flop synchroniser, then a debounce counter. The debounced level changes only after the synchronised level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the counter.
- Priority: the lowest-index debounced-pressed key wins.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If any debounced key is pressed: latch its index, flip `toggle`, load `frame`, assert `frame_valid`, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - Hold `frame_valid` and `frame` stable until `frame_valid && frame_ready`.
  - On that handshake cycle: load the gap counter with `REPEAT_GAP-1` and go to GAP.
  - Key release during SEND does not cancel the frame.
- GAP: decrement each cycle. At count 0:
  - Latched key still debounced-pressed: reassert `frame_valid` with an identical frame (same toggle) and go to SEND.
  - Otherwise: go to IDLE. A different held key is treated as a new press from IDLE, with the toggle flipped.
- The full gap is always enforced, even if the key is released early.
- Changes to other keys during SEND/GAP are ignored until IDLE.
- Reset values: `frame_valid`=0, `frame`=0, `toggle`=0, `key_active`=0, `key_index`=0, FSM=IDLE, debounced levels=0, all counters=0. The first frame after reset therefore carries toggle=1.
- Reset mid-SEND drops `frame_valid` at the next edge; the pending frame is discarded.

## Timing
- Key latency: raw edge to debounced edge is 2 (sync) + `DEBOUNCE_CYCLES` cycles.
- Debounced press seen in IDLE at cycle t: `frame_valid`=1 and the new `frame`/`toggle` are visible at t+1.
- `frame_ready` may be high before `frame_valid`. A transfer occurs in any cycle where both are high, and `frame_valid` is 0 the following cycle.
- Handshake at cycle t: GAP occupies t+1..t+REPEAT_GAP. A repeat `frame_valid` rises at t+REPEAT_GAP+1. If the key was released, the FSM is in IDLE at t+REPEAT_GAP+1.
- Back-to-back: a new key pressed and held through the gap end appears as `frame_valid` two cycles after the gap ends (GAP→IDLE→SEND).
- `key_active` is 1 exactly while the FSM is in SEND or GAP.

## Test plan
Bench parameters: NUM_KEYS=5, DEBOUNCE_CYCLES=4, REPEAT_GAP=20, ADDRESS=5'b00011, CMD_TABLE key i = 6'd(i+1), `frame_ready` held at 1 unless stated.

- Press key 2 for 10 cycles -> one frame `11_1_00011_000011`, `frame_valid` high for exactly 1 cycle, `key_index`=2.
- Glitch key 0 high for 3 cycles -> no `frame_valid`, `key_active` stays 0.
- Hold key 1 for 80 cycles -> frames spaced exactly 21 cycles apart, all with toggle=1 and cmd=000010. After release, FSM is in IDLE at the next gap end.
- Press/release key 4, then press key 4 again after the gap -> second frame has toggle=0 with cmd=000101.
- Press keys 3 and 1 in the same cycle -> frame carries cmd=000010 and `key_index`=1.
- `frame_ready`=0 for 15 cycles after `frame_valid` rises -> `frame` is stable and `frame_valid` stays high. Asserting reset in that window -> `frame_valid`=0 and `toggle`=0 on the next edge, with no transfer.
